// File: rtl/aes_iter_engine.sv
// Iterative AES-128/256 encryption engine: one round per clock, round keys expanded on the fly.
// Valid/ready on input and output; ciphertext is held until the consumer takes it.
module aes_iter_engine #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy,
  output logic [3:0]          round_cnt
);

  localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  state_t                r_fsm;
  state_t                w_fsm_nxt;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic [127:0]          r_state;
  logic [KEY_BITS-1:0]   r_key;
  logic [7:0]            r_rcon;
  logic [3:0]            r_round_cnt;
  logic [127:0]          r_ciphertext;

  logic                  w_accept;
  logic                  w_last;
  logic [127:0]          w_prev;
  logic                  w_rot;
  logic                  w_rcon_use;
  logic [127:0]          w_new;
  logic [127:0]          w_rk;
  logic [KEY_BITS-1:0]   w_key_nxt;
  logic [127:0]          w_round_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // One expansion step: four new words from the previous four plus the transformed last word.
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [31:0] last,
                                            input logic rot, input logic [7:0] rcon);
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rcon, 24'h0}) : sub_word(last);
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [127:0] res;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) begin
        res[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return res;
  endfunction

  // The 256-bit window slides by half each round; round 1 uses the key's lower half unchanged.
  generate
    if (KEY_BITS == 256) begin : g_k256
      assign w_prev     = r_key[255:128];
      assign w_rot      = ~r_round_cnt[0];
      assign w_rcon_use = w_rot;
      assign w_rk       = (r_round_cnt == 4'd1) ? r_key[127:0] : w_new;
      assign w_key_nxt  = (r_round_cnt == 4'd1) ? r_key : {r_key[127:0], w_new};
    end else if (KEY_BITS == 128) begin : g_k128
      assign w_prev     = r_key;
      assign w_rot      = 1'b1;
      assign w_rcon_use = 1'b1;
      assign w_rk       = w_new;
      assign w_key_nxt  = w_new;
    end else begin : g_bad_key_bits
      $error("aes_iter_engine: KEY_BITS must be 128 or 256");
    end
  endgenerate

  assign w_new       = key_step(w_prev, r_key[31:0], w_rot, r_rcon);
  assign w_last      = (r_round_cnt == 4'(NR));
  assign w_round_out = aes_round(r_state, w_last) ^ w_rk;
  assign w_accept    = (r_fsm == IDLE) && in_valid;

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid)  w_fsm_nxt = ROUND;
      ROUND:   if (w_last)    w_fsm_nxt = OUT;
      OUT:     if (out_ready) w_fsm_nxt = IDLE;
      default:                w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm       <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_in_ready  <= (w_fsm_nxt == IDLE);
      r_busy      <= (w_fsm_nxt == ROUND);
      r_out_valid <= (w_fsm_nxt == OUT);
    end
  end

  // Datapath: load on accept, one round per ROUND cycle, ciphertext captured on the final round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= '0;
      r_key        <= '0;
      r_rcon       <= '0;
      r_round_cnt  <= '0;
      r_ciphertext <= '0;
    end else if (w_accept) begin
      r_key       <= key;
      r_state     <= plaintext ^ key[KEY_BITS-1 -: 128];
      r_rcon      <= 8'h01;
      r_round_cnt <= 4'd1;
    end else if (r_fsm == ROUND) begin
      r_state <= w_round_out;
      r_key   <= w_key_nxt;
      if (w_rcon_use) r_rcon <= xtime(r_rcon);
      if (w_last) begin
        r_round_cnt  <= 4'd0;
        r_ciphertext <= w_round_out;
      end else begin
        r_round_cnt <= r_round_cnt + 4'd1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ciphertext;
  assign round_cnt  = r_round_cnt;

endmodule

// File: tb/tb_aes_iter_engine.sv
// Bench for aes_iter_engine: AES-128 and AES-256 instances share stimulus and are checked
// against FIPS-197 known answers and a from-first-principles AES model.
module tb_aes_iter_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic [255:0] key_bus;
  logic         in_rdy  [2];
  logic         out_vld [2];
  logic         bsy     [2];
  logic [127:0] ct      [2];
  logic [3:0]   rc      [2];

  int unsigned  cyc = 0;
  int unsigned  acc_cyc;
  int           got_lat [2];
  logic [127:0] got_ct  [2];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   sb_ref [256];

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_A256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B128 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_iter_engine #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .plaintext(plaintext), .key(key_bus[255:128]), .out_valid(out_vld[0]),
    .out_ready(out_ready), .ciphertext(ct[0]), .busy(bsy[0]), .round_cnt(rc[0]));

  aes_iter_engine #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .plaintext(plaintext), .key(key_bus), .out_valid(out_vld[1]),
    .out_ready(out_ready), .ciphertext(ct[1]), .busy(bsy[1]), .round_cnt(rc[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; s = inv;
      for (int j = 0; j < 4; j++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb_ref[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_subw(input logic [31:0] x);
    return {sb_ref[x[31:24]], sb_ref[x[23:16]], sb_ref[x[15:8]], sb_ref[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_aes(input logic [255:0] k, input logic [127:0] pt, input bit big);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    int nk, nr;
    nk = big ? 8 : 4;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = ref_subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = ref_subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_ref[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < nr) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
        for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] kk;
    for (int j = 0; j < 8; j++) kk[32*j +: 32] = $urandom;
    return kk;
  endfunction

  function automatic logic [127:0] rand_pt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic offer(input logic [255:0] k, input logic [127:0] p);
    @(negedge clk);
    key_bus = k; plaintext = p; in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_both();
    got_lat[0] = -1; got_lat[1] = -1;
    for (int i = 0; i < 40 && (got_lat[0] < 0 || got_lat[1] < 0); i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (out_vld[k] && got_lat[k] < 0) begin
          got_lat[k] = int'(cyc - acc_cyc);
          got_ct[k]  = ct[k];
        end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (out_vld[k] !== 1'b0 || bsy[k] !== 1'b0 || rc[k] !== 4'd0 || ct[k] !== 128'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got vld=%b busy=%b rc=%0d ct=%h want 0 0 0 0",
                 k, out_vld[k], bsy[k], rc[k], ct[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (in_rdy[k] !== 1'b1 || bsy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got in_ready=%b busy=%b want 1 0", k, in_rdy[k], bsy[k]);
      end
    end
  endtask

  task automatic test_kat();
    logic [127:0] exp_b256;
    offer(KEY_A, PT_A);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (bsy[k] !== 1'b1 || rc[k] !== 4'd1 || in_rdy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL first_round[%0d]: got busy=%b rc=%0d in_ready=%b want 1 1 0", k, bsy[k], rc[k], in_rdy[k]);
      end
    end
    wait_both();
    n_checks++;
    if (got_lat[0] !== 10 || got_ct[0] !== CT_A128) begin
      n_fail++;
      $display("FAIL kat_a128: got lat=%0d ct=%h want lat=10 ct=%h", got_lat[0], got_ct[0], CT_A128);
    end
    n_checks++;
    if (got_lat[1] !== 14 || got_ct[1] !== CT_A256) begin
      n_fail++;
      $display("FAIL kat_a256: got lat=%0d ct=%h want lat=14 ct=%h", got_lat[1], got_ct[1], CT_A256);
    end
    release_out();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (in_rdy[k] !== 1'b1 || out_vld[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL out_release[%0d]: got in_ready=%b out_valid=%b want 1 0", k, in_rdy[k], out_vld[k]);
      end
    end
    exp_b256 = ref_aes({KEY_B, 128'hfedcba98765432100123456789abcdef}, PT_B, 1'b1);
    offer({KEY_B, 128'hfedcba98765432100123456789abcdef}, PT_B);
    wait_both();
    n_checks++;
    if (got_ct[0] !== CT_B128) begin
      n_fail++;
      $display("FAIL kat_b128: got %h want %h", got_ct[0], CT_B128);
    end
    n_checks++;
    if (got_ct[1] !== exp_b256) begin
      n_fail++;
      $display("FAIL model_b256: got %h want %h", got_ct[1], exp_b256);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] e [2];
    for (int it = 0; it < 6; it++) begin
      k = rand_key();
      p = rand_pt();
      e[0] = ref_aes({k[255:128], 128'h0}, p, 1'b0);
      e[1] = ref_aes(k, p, 1'b1);
      offer(k, p);
      wait_both();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (got_ct[d] !== e[d] || got_lat[d] !== (d == 0 ? 10 : 14)) begin
          n_fail++;
          $display("FAIL random[%0d][%0d]: got lat=%0d ct=%h want ct=%h", it, d, got_lat[d], got_ct[d], e[d]);
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] e [2];
    k = rand_key();
    p = rand_pt();
    e[0] = ref_aes({k[255:128], 128'h0}, p, 1'b0);
    e[1] = ref_aes(k, p, 1'b1);
    offer(k, p);
    wait_both();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (ct[d] !== e[d] || out_vld[d] !== 1'b1 || in_rdy[d] !== 1'b0 || bsy[d] !== 1'b0 || rc[d] !== 4'd0) begin
          n_fail++;
          $display("FAIL backpressure[%0d] cycle %0d: got ct=%h vld=%b rdy=%b busy=%b rc=%0d want ct=%h 1 0 0 0",
                   d, i, ct[d], out_vld[d], in_rdy[d], bsy[d], rc[d], e[d]);
        end
      end
      key_bus = rand_key();
      plaintext = rand_pt();
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_rdy[d] !== 1'b1 || bsy[d] !== 1'b0 || out_vld[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL no_queue[%0d]: got rdy=%b busy=%b vld=%b want 1 0 0", d, in_rdy[d], bsy[d], out_vld[d]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit hit;
    hit = 1'b0;
    offer(KEY_A, PT_A);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (rc[0] === 4'd5) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reach_round5: got timeout want rc=5");
    end
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (out_vld[d] !== 1'b0 || bsy[d] !== 1'b0 || rc[d] !== 4'd0 || ct[d] !== 128'd0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got vld=%b busy=%b rc=%0d ct=%h want all 0", d, out_vld[d], bsy[d], rc[d], ct[d]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (out_vld[d] !== 1'b0 || bsy[d] !== 1'b0 || rc[d] !== 4'd0) begin
        n_fail++;
        $display("FAIL held_reset[%0d]: got vld=%b busy=%b rc=%0d want 0 0 0", d, out_vld[d], bsy[d], rc[d]);
      end
    end
    key_bus = KEY_A; plaintext = PT_A; in_valid = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (bsy[d] !== 1'b1 || rc[d] !== 4'd1) begin
        n_fail++;
        $display("FAIL first_edge_accept[%0d]: got busy=%b rc=%0d want 1 1", d, bsy[d], rc[d]);
      end
    end
    wait_both();
    n_checks++;
    if (got_lat[0] !== 10 || got_ct[0] !== CT_A128) begin
      n_fail++;
      $display("FAIL rerun_a128: got lat=%0d ct=%h want lat=10 ct=%h", got_lat[0], got_ct[0], CT_A128);
    end
    n_checks++;
    if (got_lat[1] !== 14 || got_ct[1] !== CT_A256) begin
      n_fail++;
      $display("FAIL rerun_a256: got lat=%0d ct=%h want lat=14 ct=%h", got_lat[1], got_ct[1], CT_A256);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] e [2];
    int unsigned acc [2][2];
    int na [2];
    bit seen [2];
    logic [127:0] first_ct [2];
    k = rand_key();
    p = rand_pt();
    e[0] = ref_aes({k[255:128], 128'h0}, p, 1'b0);
    e[1] = ref_aes(k, p, 1'b1);
    na[0] = 0; na[1] = 0; seen[0] = 1'b0; seen[1] = 1'b0;
    first_ct[0] = '0; first_ct[1] = '0;
    @(negedge clk);
    key_bus = k; plaintext = p; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && (na[0] < 2 || na[1] < 2); i++) begin
      for (int d = 0; d < 2; d++) begin
        if (in_rdy[d] && na[d] < 2) begin
          acc[d][na[d]] = cyc + 1;
          na[d]++;
        end
        if (out_vld[d] && !seen[d]) begin
          seen[d] = 1'b1;
          first_ct[d] = ct[d];
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (na[d] != 2 || int'(acc[d][1] - acc[d][0]) != (d == 0 ? 12 : 16)) begin
        n_fail++;
        $display("FAIL back_to_back_spacing[%0d]: got accepts=%0d spacing=%0d want 2 %0d",
                 d, na[d], int'(acc[d][1] - acc[d][0]), (d == 0 ? 12 : 16));
      end
      n_checks++;
      if (!seen[d] || first_ct[d] !== e[d]) begin
        n_fail++;
        $display("FAIL back_to_back_ct[%0d]: got %h want %h", d, first_ct[d], e[d]);
      end
    end
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key_bus = '0;
    init_sbox();
    test_reset();
    test_kat();
    test_random();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_iter_engine.md
AES_ITER_ENGINE -- requirements
Module: aes_iter_engine

Interface
REQ-001 The block SHALL have parameter KEY_BITS, default 128, giving the cipher key length; legal values are 128 (Nr=10) and 256 (Nr=14).
REQ-002 The block SHALL fail elaboration when KEY_BITS is not 128 or 256.
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit; it is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning a block and key are offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the engine accepts an offered block.
REQ-007 The block SHALL have port plaintext, input, 128 bits; byte 0 is [127:120], per FIPS-197 order.
REQ-008 The block SHALL have port key, input, KEY_BITS bits; byte 0 is the MSB byte.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning ciphertext is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes ciphertext.
REQ-011 The block SHALL have port ciphertext, output, 128 bits, the AES encryption result.
REQ-012 The block SHALL have port busy, output, 1 bit, high while rounds are in progress.
REQ-013 The block SHALL have port round_cnt, output, 4 bits, the index of the current round.

Function
REQ-014 FSM states SHALL be IDLE, ROUND and OUT, with IDLE being the reset state.
REQ-015 in_ready SHALL be 1 exactly in IDLE, busy SHALL be 1 exactly in ROUND, and out_valid SHALL be 1 exactly in OUT.
REQ-016 Accept occurs when in_valid and in_ready are both 1 on a clk edge.
- Action: capture key in the key window register; state_reg <= plaintext ^ key[KEY_BITS-1 -: 128]; round_cnt <= 1.
- Transition: IDLE -> ROUND.
REQ-017 Inputs SHALL be ignored after accept, and changing plaintext or key during ROUND or OUT SHALL have no effect.
REQ-018 Each ROUND cycle SHALL update state_reg as follows.
- Rounds 1..Nr-1: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk[round_cnt].
- Round Nr: MixColumns is omitted.
REQ-019 Round keys SHALL be generated on the fly, one per ROUND cycle, from the key window register and an Rcon register; the block SHALL NOT store a precomputed key table.
- KEY_BITS=128: rk[i] = expansion words 4i..4i+3.
- KEY_BITS=256: the window holds 8 words; rk[1] = key[127:0]; subsequent rk alternate between the new half words 8j.. (RotWord+SubWord+Rcon) and 8j+4.. (SubWord only).
REQ-020 The Rcon register SHALL start at 0x01 on accept and advance by xtime (GF(2^8) doubling with 0x1B reduction) each time it is consumed.
REQ-021 In ROUND, round_cnt SHALL increment each cycle; when round_cnt==Nr the FSM goes ROUND -> OUT, and ciphertext <= the round-Nr result.
REQ-022 The latency from the accept edge to out_valid rising SHALL be Nr clock edges (10 or 14).
REQ-023 In OUT, ciphertext and out_valid SHALL hold stable while out_ready=0, with unbounded backpressure.
REQ-024 In OUT, out_ready=1 SHALL transfer the block and move OUT -> IDLE; in_ready is 1 in the next cycle.
REQ-025 Maximum throughput SHALL be one block per Nr+2 cycles, and acceptance SHALL NOT overlap OUT.
REQ-026 in_valid in ROUND or OUT SHALL be ignored, with no queueing.
REQ-027 round_cnt SHALL read 0 in IDLE and OUT.
REQ-028 ciphertext SHALL update only on the ROUND -> OUT transition.

Reset
REQ-029 Assertion of reset SHALL immediately force the following, independent of clk:
- state IDLE;
- in_ready=1 after reset is released;
- out_valid=0, busy=0, round_cnt=0;
- ciphertext=0; state_reg, key window and Rcon cleared.
REQ-030 Reset during ROUND or OUT SHALL abandon the block in flight, and no out_valid SHALL be produced for it.
REQ-031 The first accept after reset SHALL be permitted on the first clk edge with reset low.

Verification
REQ-032 KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid 10 edges after accept.
REQ-033 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32.
REQ-034 KEY_BITS=256, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> ciphertext 8ea2b7ca516745bfeafc49904b496089, with out_valid 14 edges after accept.
REQ-035 Backpressure: hold out_ready=0 for 20 cycles while toggling plaintext and key -> ciphertext and out_valid stay stable, in_ready=0, and a second in_valid is not accepted.
REQ-036 Reset is asserted at round_cnt=5, then REQ-032 is rerun -> outputs are 0 during reset, there is no spurious out_valid, and the correct ciphertext is produced.
REQ-037 Back-to-back: in_valid and out_ready are held at 1 for two blocks -> the second accept occurs exactly Nr+2 edges after the first.
